// File: rtl/uart_pkg.sv
// uart_pkg: state encoding and frame defaults shared by the UART receiver and transmitter.
package uart_pkg;
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} rx_state_t;
    localparam int UART_SIZE = 8;
    localparam int UART_OVERSAMPLE = 16;
endpackage

// File: rtl/sync2.sv
// sync2: two-flop synchroniser for an idle-high asynchronous input.
module sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);
    logic meta;
    always_ff @(posedge clk)
        if (!rst_n) {q, meta} <= 2'b11;
        else {q, meta} <= {meta, d};
endmodule

// File: rtl/uart_rx.sv
// uart_rx: oversampled UART receiver with ready/acknowledge output and sticky framing/overrun flags.
module uart_rx
    import uart_pkg::*;
#(
    parameter int SIZE = UART_SIZE,
    parameter int OVERSAMPLE = UART_OVERSAMPLE
) (
    input  logic            CLK,
    input  logic            RST_N,
    input  logic            RXD,
    input  logic            RX_ACK,
    output logic [SIZE-1:0] RXDATA,
    output logic            RX_RDY,
    output logic            RX_ERR,
    output logic            RX_OVR,
    output logic            RX_BUSY
);
    localparam int CW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(SIZE + 1);
    localparam logic [CW-1:0] HALF = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] LAST = CW'(OVERSAMPLE - 1);

    rx_state_t       state, state_n;
    logic            rxd_s;
    logic [CW-1:0]   cnt;
    logic [BW-1:0]   bitc;
    logic [SIZE-1:0] shift;
    logic            tick_half, tick_full, last_bit, good, bad, held;

    sync2 u_sync (.clk(CLK), .rst_n(RST_N), .d(RXD), .q(rxd_s));

    assign tick_half = cnt == HALF;
    assign tick_full = cnt == LAST;
    assign last_bit  = bitc == BW'(SIZE - 1);
    assign good      = state == STOP && tick_full && rxd_s;
    assign bad       = state == STOP && tick_full && !rxd_s;
    assign held      = RX_RDY && !RX_ACK;
    assign RX_BUSY   = state != IDLE;

    always_ff @(posedge CLK)
        if (!RST_N) state <= IDLE;
        else state <= state_n;

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (!rxd_s) state_n = START;
            START:   if (tick_half) state_n = rxd_s ? IDLE : DATA;
            DATA:    if (tick_full && last_bit) state_n = STOP;
            STOP:    if (tick_full) state_n = rxd_s ? IDLE : BREAK;
            BREAK:   if (rxd_s) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Acknowledge is applied before the frame result, so a same-cycle ack frees the buffer.
    always_ff @(posedge CLK)
        if (!RST_N) begin
            cnt    <= '0;
            bitc   <= '0;
            shift  <= '0;
            RXDATA <= '0;
            RX_RDY <= 1'b0;
            RX_ERR <= 1'b0;
            RX_OVR <= 1'b0;
        end else begin
            cnt <= (state == IDLE || (state == START && tick_half) || tick_full) ? '0 : cnt + 1'b1;
            if (state == DATA && tick_full) begin
                shift <= {rxd_s, shift[SIZE-1:1]};
                bitc  <= last_bit ? '0 : bitc + 1'b1;
            end
            if (good && !held) RXDATA <= shift;
            RX_RDY <= good || held;
            RX_ERR <= bad || (RX_ERR && !RX_ACK);
            RX_OVR <= (good && held) || (RX_OVR && !RX_ACK);
        end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed vector table plus timed corner sequences for uart_rx.
module tb_uart_rx;
    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic       RXD = 1'b1;
    logic       RX_ACK = 1'b0;
    logic [7:0] RXDATA;
    logic       RX_RDY, RX_ERR, RX_OVR, RX_BUSY;
    int         cyc;
    int         checks = 0;
    int         errors = 0;

    uart_rx #(.SIZE(8), .OVERSAMPLE(16)) dut (
        .CLK(CLK), .RST_N(RST_N), .RXD(RXD), .RX_ACK(RX_ACK),
        .RXDATA(RXDATA), .RX_RDY(RX_RDY), .RX_ERR(RX_ERR), .RX_OVR(RX_OVR), .RX_BUSY(RX_BUSY)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] d;
        logic       sb;
        int         hold;
        logic       ack;
        logic [7:0] xd;
        logic       xr, xe, xo;
    } vec_t;
    vec_t v[8];

    task automatic step(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Bit edges fall at ceil(i*per100/100) cycles, so per100 != 1600 models baud skew.
    task automatic send_frame(input logic [7:0] d, input logic sb, input int per100);
        int s;
        logic [9:0] bits;
        s = cyc;
        bits = {sb, d, 1'b0};
        for (int i = 0; i < 10; i++) begin
            RXD = bits[i];
            while ((cyc - s) * 100 < (i + 1) * per100) step(1);
        end
        RXD = 1'b1;
    endtask

    task automatic pulse_ack();
        RX_ACK = 1'b1;
        step(1);
        RX_ACK = 1'b0;
    endtask

    initial begin
        int start, busy_at, rdy_at, n1, n2, got;
        v[0] = '{8'h3C, 1'b1, 0,  1'b1, 8'h3C, 1'b1, 1'b0, 1'b0};
        v[1] = '{8'h55, 1'b0, 40, 1'b0, 8'h3C, 1'b0, 1'b1, 1'b0};
        v[2] = '{8'h0F, 1'b1, 0,  1'b1, 8'h0F, 1'b1, 1'b1, 1'b0};
        v[3] = '{8'h11, 1'b1, 0,  1'b0, 8'h11, 1'b1, 1'b0, 1'b0};
        v[4] = '{8'h22, 1'b1, 0,  1'b1, 8'h11, 1'b1, 1'b0, 1'b1};
        v[5] = '{8'h00, 1'b1, 0,  1'b1, 8'h00, 1'b1, 1'b0, 1'b0};
        v[6] = '{8'hFF, 1'b1, 0,  1'b1, 8'hFF, 1'b1, 1'b0, 1'b0};
        v[7] = '{8'hAA, 1'b0, 40, 1'b1, 8'hFF, 1'b0, 1'b1, 1'b0};

        step(3);
        chk("reset data", RXDATA, 8'h00);
        chk("reset flags", {RX_RDY, RX_ERR, RX_OVR, RX_BUSY}, 4'b0000);
        RST_N = 1'b1;
        step(2);

        // Exact latency of a nominal frame, measured from the RXD falling edge.
        start = cyc;
        busy_at = 0;
        rdy_at = 0;
        fork
            send_frame(8'hA5, 1'b1, 1600);
            begin
                n1 = 0;
                while (!RX_BUSY && n1 < 50) begin step(1); n1++; end
                busy_at = cyc;
            end
            begin
                n2 = 0;
                while (!RX_RDY && n2 < 300) begin step(1); n2++; end
                rdy_at = cyc;
                chk("a5 data", RXDATA, 8'hA5);
                chk("a5 err/ovr", {RX_ERR, RX_OVR}, 2'b00);
            end
        join
        chk("busy rise", busy_at - start, 3);
        chk("rdy latency", rdy_at - start, 155);
        step(start + 162 - cyc);
        chk("rdy held", RX_RDY, 1'b1);
        pulse_ack();
        chk("rdy after ack", RX_RDY, 1'b0);

        // False start: a 6-cycle low pulse must be rejected at the half-bit check.
        start = cyc;
        RXD = 1'b0;
        step(6);
        RXD = 1'b1;
        step(start + 3 - cyc);
        chk("false start busy", RX_BUSY, 1'b1);
        step(start + 11 - cyc);
        chk("false start idle", RX_BUSY, 1'b0);
        step(200);
        chk("false start rdy", {RX_RDY, RX_ERR}, 2'b00);

        for (int i = 0; i < 8; i++) begin
            send_frame(v[i].d, v[i].sb, 1600);
            if (v[i].hold > 0) begin
                RXD = 1'b0;
                step(v[i].hold);
                RXD = 1'b1;
            end
            step(20);
            chk($sformatf("v%0d data", i), RXDATA, v[i].xd);
            chk($sformatf("v%0d rdy", i), RX_RDY, v[i].xr);
            chk($sformatf("v%0d err", i), RX_ERR, v[i].xe);
            chk($sformatf("v%0d ovr", i), RX_OVR, v[i].xo);
            if (v[i].ack) pulse_ack();
        end
        chk("ack while idle clears", {RX_RDY, RX_ERR, RX_OVR}, 3'b000);

        // Overrun avoided: ack coincides with the stop-update edge.
        send_frame(8'h11, 1'b1, 1600);
        step(20);
        start = cyc;
        fork
            send_frame(8'h22, 1'b1, 1600);
            begin
                step(154);
                pulse_ack();
            end
        join
        step(5);
        chk("ack+good data", RXDATA, 8'h22);
        chk("ack+good flags", {RX_RDY, RX_ERR, RX_OVR}, 3'b100);

        // Reset pulse during data bit 3 aborts the frame and clears held outputs.
        start = cyc;
        fork
            send_frame(8'hFF, 1'b1, 1600);
            begin
                step(70);
                RST_N = 1'b0;
                step(1);
                RST_N = 1'b1;
                chk("mid reset data", RXDATA, 8'h00);
                chk("mid reset flags", {RX_RDY, RX_ERR, RX_OVR, RX_BUSY}, 4'b0000);
            end
        join
        step(20);
        chk("post reset quiet", {RX_RDY, RX_ERR, RX_BUSY}, 3'b000);
        send_frame(8'h81, 1'b1, 1600);
        step(20);
        chk("post reset frame", {RX_RDY, RX_ERR, RX_OVR, RXDATA}, {3'b100, 8'h81});
        pulse_ack();

        // Back-to-back frames at -4% and +4% bit period, acknowledged as they arrive.
        for (int p = 0; p < 2; p++) begin
            got = 0;
            fork
                for (int k = 0; k < 4; k++) send_frame(8'hC3, 1'b1, p == 0 ? 1536 : 1664);
                begin
                    for (int n = 0; n < 4 * 170 + 30; n++) begin
                        RX_ACK = RX_RDY;
                        if (RX_RDY) begin
                            got++;
                            chk($sformatf("skew%0d byte%0d", p, got), RXDATA, 8'hC3);
                        end
                        step(1);
                    end
                    RX_ACK = 1'b0;
                end
            join
            chk($sformatf("skew%0d count", p), got, 4);
            chk($sformatf("skew%0d flags", p), {RX_ERR, RX_OVR, RX_BUSY}, 3'b000);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
